// File: rtl/mcc_pkg.sv
// Shared types and constants for the multi-cycle controller.
package mcc_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StError
    } state_e;

    // Instruction classes taken from instr[11:10].
    typedef enum logic [1:0] {
        ClsDpReg = 2'b00,
        ClsDpImm = 2'b01,
        ClsLdr   = 2'b10,
        ClsStr   = 2'b11
    } cls_e;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] ImmDp  = 2'b00;
    localparam logic [1:0] ImmMem = 2'b01;
    localparam logic [3:0] PcIdx  = 4'hF;

    // Decoded control bundle handed from the decoder to the sequencer.
    typedef struct packed {
        cls_e       cls;
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic       alu_src;
        logic [1:0] alu_ctrl;
        logic       mem_to_reg;
        logic       pc_dest;
    } ctrl_t;

endpackage

// File: rtl/mcc_decoder.sv
// Combinational instruction decode into the datapath control bundle.
module mcc_decoder
    import mcc_pkg::*;
(
    input  logic [11:0] instr_i,
    output ctrl_t       ctrl_o
);

    cls_e cls;
    logic unused_instr;

    assign cls          = cls_e'(instr_i[11:10]);
    // Bits [9:6] carry operand fields the controller does not look at.
    assign unused_instr = ^instr_i[9:6];

    // Map the instruction class onto datapath controls.
    always_comb begin
        ctrl_o            = '0;
        ctrl_o.cls        = cls;
        ctrl_o.pc_dest    = (instr_i[5:2] == PcIdx);
        unique case (cls)
            ClsDpReg: begin
                ctrl_o.alu_src  = 1'b0;
                ctrl_o.imm_src  = ImmDp;
                ctrl_o.alu_ctrl = instr_i[1:0];
            end
            ClsDpImm: begin
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.imm_src  = ImmDp;
                ctrl_o.alu_ctrl = AluAdd;
            end
            ClsLdr: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.imm_src    = ImmMem;
                ctrl_o.alu_ctrl   = AluAdd;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ClsStr: begin
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.imm_src  = ImmMem;
                ctrl_o.alu_ctrl = AluAdd;
                // Second read port must fetch the store data register.
                ctrl_o.reg_src  = 2'b10;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 12-bit ARM-style datapath: FSM, memory
// handshakes, NZCV flags, timeout watchdog and retired-instruction counter.
module multicycle_controller
    import mcc_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [11:0]         instr,
    input  logic [3:0]          alu_flags,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          RegisterSrc,
    output logic                RegisterWrite,
    output logic [1:0]          ImmSrc,
    output logic                ALUSrc,
    output logic [1:0]          ALUControl,
    output logic                MemorytoRegister,
    output logic                PCSrc,
    output logic [3:0]          flags,
    output logic                busy,
    output logic                bus_error,
    output logic [RETIRE_W-1:0] retired
);

    localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] WaitLim = CntW'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     wait_q, wait_d;
    logic [3:0]          flags_q, flags_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    ctrl_t               ctrl;
    logic                drive_ctrl;

    mcc_decoder u_decoder (
        .instr_i (instr),
        .ctrl_o  (ctrl)
    );

    assign flags     = flags_q;
    assign retired   = retired_q;
    assign busy      = (state_q != StIdle) && (state_q != StError);

    // State, watchdog, flags and retire counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            flags_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            flags_q   <= flags_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic and all control outputs.
    always_comb begin
        state_d          = state_q;
        // Any cycle outside a wait state zeroes the counter, so FETCH/MEM entry starts at 0.
        wait_d           = '0;
        flags_d          = flags_q;
        retired_d        = retired_q;
        drive_ctrl       = 1'b0;
        imem_req         = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        RegisterWrite    = 1'b0;
        PCSrc            = 1'b0;
        bus_error        = 1'b0;
        RegisterSrc      = 2'b00;
        ImmSrc           = 2'b00;
        ALUSrc           = 1'b0;
        ALUControl       = 2'b00;
        MemorytoRegister = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                // Ready on the limit cycle still wins over the timeout.
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end else if (wait_q == WaitLim) begin
                    state_d = StError;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                drive_ctrl = 1'b1;
                state_d    = StExec;
            end
            StExec: begin
                drive_ctrl = 1'b1;
                if (ctrl.cls == ClsDpReg) flags_d = alu_flags;
                state_d = (ctrl.cls == ClsLdr || ctrl.cls == ClsStr) ? StMem : StWb;
            end
            StMem: begin
                drive_ctrl = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = (ctrl.cls == ClsStr);
                if (dmem_ready) begin
                    if (ctrl.cls == ClsStr) begin
                        pc_write  = 1'b1;
                        retired_d = retired_q + 1'b1;
                        state_d   = run ? StFetch : StIdle;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_q == WaitLim) begin
                    state_d = StError;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWb: begin
                drive_ctrl    = 1'b1;
                RegisterWrite = 1'b1;
                pc_write      = 1'b1;
                PCSrc         = ctrl.pc_dest;
                retired_d     = retired_q + 1'b1;
                state_d       = run ? StFetch : StIdle;
            end
            StError: begin
                bus_error = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (drive_ctrl) begin
            RegisterSrc      = ctrl.reg_src;
            ImmSrc           = ctrl.imm_src;
            ALUSrc           = ctrl.alu_src;
            ALUControl       = ctrl.alu_ctrl;
            MemorytoRegister = ctrl.mem_to_reg;
        end
    end

endmodule
